tt_um_clk_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the successor to the single-function clocked AND core. Each accepted beat applies one of eight operations, selected per beat, to operands `a`/`b`. Supported operations are six two-operand bitwise functions and two accumulate modes that fold `a` into an internal register. The result emerges after a fixed, parameter-set latency with a valid flag, a global stall and a result counter. It sits directly under the TinyTapeout top wrapper, replacing the fixed AND core.

---
 rtl/tt_um_clk_logic_pipe_if.sv | 25 ++
 rtl/tt_um_clk_logic_pipe.sv | 87 ++++++++
 tb/tb_tt_um_clk_logic_pipe.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_clk_logic_pipe_if.sv
// Beat/result bundle for the pipelined logic unit; the DUT takes the slave side.
// en is carried here because it qualifies every beat and result.
interface tt_um_clk_logic_pipe_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             in_valid;
  logic [2:0]       op;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic [7:0]       res_cnt;

  modport master (
    output en, in_valid, op, acc_clr, a, b,
    input  y, out_valid, res_cnt
  );

  modport slave (
    input  en, in_valid, op, acc_clr, a, b,
    output y, out_valid, res_cnt
  );
endinterface

// File: rtl/tt_um_clk_logic_pipe.sv
// Per-beat bitwise/accumulate logic unit; result after LATENCY en-cycles, one beat per en-cycle.
// No backpressure: en=0 freezes every register, including the accumulator and result counter.
module tt_um_clk_logic_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  tt_um_clk_logic_pipe_if.slave bus
);

  typedef logic [WIDTH-1:0] word_t;

  word_t              acc_q, acc_d, acc_nxt, res_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  word_t              dat_q [LATENCY];
  word_t              dat_d [LATENCY];
  logic [7:0]         res_cnt_q, res_cnt_d;
  logic               fold;

  always_comb begin
    fold    = bus.in_valid && (bus.op[2:1] == 2'b11);
    acc_nxt = acc_q;
    // A clear overrides a fold on the same beat, so the issued value is b.
    if (bus.acc_clr) begin
      acc_nxt = bus.b;
    end else if (fold) begin
      acc_nxt = bus.op[0] ? (acc_q | bus.a) : (acc_q & bus.a);
    end

    res_d = acc_nxt;
    case (bus.op)
      3'b000:  res_d = bus.a & bus.b;
      3'b001:  res_d = bus.a | bus.b;
      3'b010:  res_d = bus.a ^ bus.b;
      3'b011:  res_d = ~(bus.a & bus.b);
      3'b100:  res_d = ~(bus.a | bus.b);
      3'b101:  res_d = ~(bus.a ^ bus.b);
      default: res_d = acc_nxt;
    endcase

    acc_d     = acc_q;
    vld_d     = vld_q;
    dat_d     = dat_q;
    res_cnt_d = res_cnt_q;
    if (bus.en) begin
      acc_d    = acc_nxt;
      vld_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        dat_d[0] = res_d;
      end
      // Data registers only load behind a valid bit so y holds between beats.
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_d[i] = dat_q[i-1];
        end
      end
      if (vld_d[LATENCY-1]) begin
        res_cnt_d = res_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      vld_q     <= '0;
      res_cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      res_cnt_q <= res_cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign bus.y         = dat_q[LATENCY-1];
  assign bus.out_valid = vld_q[LATENCY-1];
  assign bus.res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_tt_um_clk_logic_pipe.sv
// Drives a LATENCY=1 and a LATENCY=3 instance with identical beats; expected results
// are queued at drive time and popped when each instance delivers a result.
module tb_tt_um_clk_logic_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_um_clk_logic_pipe_if #(.WIDTH(8)) if1 ();
  tt_um_clk_logic_pipe_if #(.WIDTH(8)) if3 ();

  tt_um_clk_logic_pipe #(.WIDTH(8), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  tt_um_clk_logic_pipe #(.WIDTH(8), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int checks   = 0;
  int failures = 0;
  logic [7:0] q1[$];
  logic [7:0] q3[$];
  logic [7:0] m_acc;

  // Scoreboard monitors: a result counts only if en was high at the edge.
  always @(posedge clk) begin : mon1
    logic       en_s;
    logic [7:0] e;
    en_s = if1.en;
    #1;
    if (rst_n && en_s && if1.out_valid) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL mon_lat1 unexpected out_valid y=%h expected none", if1.y);
      end else begin
        e = q1.pop_front();
        if (if1.y !== e) begin
          failures++;
          $display("FAIL mon_lat1 y=%h expected %h", if1.y, e);
        end
      end
    end
  end

  always @(posedge clk) begin : mon3
    logic       en_s;
    logic [7:0] e;
    en_s = if3.en;
    #1;
    if (rst_n && en_s && if3.out_valid) begin
      checks++;
      if (q3.size() == 0) begin
        failures++;
        $display("FAIL mon_lat3 unexpected out_valid y=%h expected none", if3.y);
      end else begin
        e = q3.pop_front();
        if (if3.y !== e) begin
          failures++;
          $display("FAIL mon_lat3 y=%h expected %h", if3.y, e);
        end
      end
    end
  end

  function automatic logic [7:0] pred(input logic [2:0] o, input logic c,
                                      input logic [7:0] aa, input logic [7:0] bb);
    logic [7:0] n;
    n = c ? bb : (o[0] ? (m_acc | aa) : (m_acc & aa));
    case (o)
      3'd0:    return aa & bb;
      3'd1:    return aa | bb;
      3'd2:    return aa ^ bb;
      3'd3:    return ~(aa & bb);
      3'd4:    return ~(aa | bb);
      3'd5:    return ~(aa ^ bb);
      default: return n;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic [2:0] o, input logic c,
                        input logic [7:0] aa, input logic [7:0] bb);
    if1.in_valid = v;  if3.in_valid = v;
    if1.op       = o;  if3.op       = o;
    if1.acc_clr  = c;  if3.acc_clr  = c;
    if1.a        = aa; if3.a        = aa;
    if1.b        = bb; if3.b        = bb;
  endtask

  task automatic set_en(input logic e);
    if1.en = e;
    if3.en = e;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic c,
                       input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] exp);
    @(negedge clk);
    set_in(v, o, c, aa, bb);
    if (if1.en && v) begin
      q1.push_back(exp);
      q3.push_back(exp);
    end
    if (if1.en) begin
      if (c) m_acc = bb;
      else if (v && o[2:1] == 2'b11) m_acc = o[0] ? (m_acc | aa) : (m_acc & aa);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    set_in(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending lat1=%0d lat3=%0d expected 0", name, q1.size(), q3.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q1.delete();
    q3.delete();
    m_acc = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_en(1'b1);
    set_in(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    m_acc = 8'h00;
    #1;
    checks++;
    if (if1.y !== 8'h00 || if1.out_valid !== 1'b0 || if1.res_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_init y=%h ov=%b cnt=%0d expected 00/0/0", if1.y, if1.out_valid, if1.res_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 8'hFF, 8'h5A, 8'h5A);
    drive(1'b1, 3'd7, 1'b0, 8'h01, 8'h00, 8'h5B);
    drive(1'b1, 3'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    set_in(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    q1.delete();
    q3.delete();
    m_acc = 8'h00;
    #1;
    checks++;
    if (if1.y !== 8'h00 || if1.out_valid !== 1'b0 || if1.res_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_lat1 y=%h ov=%b cnt=%0d expected 00/0/0", if1.y, if1.out_valid, if1.res_cnt);
    end
    checks++;
    if (if3.y !== 8'h00 || if3.out_valid !== 1'b0 || if3.res_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_lat3 y=%h ov=%b cnt=%0d expected 00/0/0", if3.y, if3.out_valid, if3.res_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'd7, 1'b0, 8'h00, 8'h00, 8'h00);
    idle();
    drain("reset_acc");
    checks++;
    if (if3.res_cnt !== 8'd1) begin
      failures++;
      $display("FAIL reset_cnt res_cnt=%0d expected 1", if3.res_cnt);
    end
  endtask

  task automatic test_two_op();
    logic [7:0] exp_tab [6];
    exp_tab = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 1'b0, 8'hCC, 8'hAA, exp_tab[i]);
    end
    idle();
    drain("two_op");
    checks++;
    if (if1.res_cnt !== 8'd6 || if3.res_cnt !== 8'd6) begin
      failures++;
      $display("FAIL two_op_cnt lat1=%0d lat3=%0d expected 6", if1.res_cnt, if3.res_cnt);
    end
  endtask

  task automatic test_latency3();
    int first;
    int pulses;
    drive(1'b1, 3'd2, 1'b0, 8'h3C, 8'h0F, 8'h33);
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) set_in(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      if (if3.out_valid) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (first != 3 || pulses != 1) begin
      failures++;
      $display("FAIL lat3_single first_edge=%0d pulses=%0d expected 3/1", first, pulses);
    end
    checks++;
    if (if3.y !== 8'h33 || if3.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat3_hold y=%h ov=%b expected 33/0", if3.y, if3.out_valid);
    end

    drive(1'b1, 3'd4, 1'b0, 8'h0F, 8'h30, 8'hC0);
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        set_in(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        set_en(1'b0);
      end
      if (k == 3) set_en(1'b1);
      if (k == 4) begin
        checks++;
        if (if3.y !== 8'h33) begin
          failures++;
          $display("FAIL lat3_stall_hold y=%h expected 33", if3.y);
        end
      end
      if (if3.out_valid) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (first != 5 || pulses != 1 || if3.y !== 8'hC0) begin
      failures++;
      $display("FAIL lat3_stall first_edge=%0d pulses=%0d y=%h expected 5/1/c0", first, pulses, if3.y);
    end
    drain("lat3");
  endtask

  task automatic test_acc_chain();
    drive(1'b1, 3'd6, 1'b1, 8'h00, 8'hFF, 8'hFF);
    drive(1'b1, 3'd6, 1'b0, 8'hF0, 8'h00, 8'hF0);
    drive(1'b1, 3'd6, 1'b0, 8'h3C, 8'h00, 8'h30);
    drive(1'b1, 3'd7, 1'b0, 8'h05, 8'h00, 8'h35);
    drive(1'b1, 3'd2, 1'b0, 8'h01, 8'h01, 8'h00);
    drive(1'b1, 3'd7, 1'b0, 8'h00, 8'h00, 8'h35);
    idle();
    drain("acc_chain");
  endtask

  task automatic test_clear_fold();
    drive(1'b0, 3'd0, 1'b1, 8'h00, 8'h0F, 8'h00);
    drive(1'b1, 3'd7, 1'b1, 8'hFF, 8'hA0, 8'hA0);
    drive(1'b1, 3'd7, 1'b0, 8'h01, 8'h00, 8'hA1);
    idle();
    drain("clear_fold");
  endtask

  task automatic test_counter_wrap();
    logic [2:0] o;
    logic       c;
    logic [7:0] aa, bb;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      o  = 3'($urandom_range(0, 7));
      c  = ($urandom_range(0, 7) == 0);
      aa = 8'($urandom_range(0, 255));
      bb = 8'($urandom_range(0, 255));
      drive(1'b1, o, c, aa, bb, pred(o, c, aa, bb));
    end
    idle();
    drain("wrap");
    checks++;
    if (if1.res_cnt !== 8'd1 || if3.res_cnt !== 8'd1) begin
      failures++;
      $display("FAIL wrap_cnt lat1=%0d lat3=%0d expected 1", if1.res_cnt, if3.res_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (if1.res_cnt !== 8'd1 || if3.res_cnt !== 8'd1) begin
      failures++;
      $display("FAIL idle_cnt lat1=%0d lat3=%0d expected 1", if1.res_cnt, if3.res_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_op();
    test_latency3();
    test_acc_chain();
    test_clear_fold();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
